// File: rtl/bus_pkg.sv
// Shared definitions for the cartridge address-bus initiator: slice selects,
// address widths, channel FSM states and the AS-to-F-bus bit packing.
package bus_pkg;

    localparam logic [1:0] JS_LO = 2'b00;
    localparam logic [1:0] JS_HI = 2'b01;
    localparam logic [1:0] FS_AS = 2'b11;

    localparam int A68K_AW = 19;
    localparam int AS_AW   = 17;

    typedef enum logic [1:0] {CH_IDLE, CH_REQ, CH_HOLD} ch_state_t;

    // F bus layout: f[15]=a4, f[14:12]=a2..a0, f[11:0]=a16..a5; a3 is not carried.
    function automatic logic [15:0] as_encode(input logic [AS_AW-1:0] a);
        return {a[4], a[2:0], a[16:5]};
    endfunction

endpackage

// File: rtl/bus_req_chan.sv
// One request channel: captures an address on valid/ready, strobes the CPLD for
// one cycle, then keeps the bus enabled for GAP-1 more cycles before re-arming.
module bus_req_chan
    import bus_pkg::*;
#(
    parameter int AW  = 19,
    parameter int GAP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    output logic          ready,
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] hold,
    output logic          strobe,
    output logic          oe
);

    localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;
    // HOLD spans GAP-1 cycles, so the counter is loaded with GAP-2 and exits at 0.
    localparam logic [CW-1:0] HOLD_LD = CW'((GAP >= 2) ? GAP - 2 : 0);

    generate
        if (GAP < 1) begin : g_bad_gap
            $error("bus_req_chan: GAP must be >= 1");
        end
    endgenerate

    ch_state_t     state, nxt;
    logic [CW-1:0] ctr;
    logic          up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CH_IDLE;
            ctr   <= '0;
            hold  <= '0;
            up    <= 1'b0;
        end else begin
            up    <= 1'b1;
            state <= nxt;
            if (valid && ready) hold <= addr;
            if (state == CH_REQ)       ctr <= HOLD_LD;
            else if (state == CH_HOLD) ctr <= ctr - 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            CH_IDLE: if (valid && ready) nxt = CH_REQ;
            CH_REQ:  nxt = (GAP > 1) ? CH_HOLD : CH_IDLE;
            CH_HOLD: if (ctr == '0) nxt = CH_IDLE;
            default: nxt = CH_IDLE;
        endcase
    end

    // ready is held off until the first edge after reset release.
    assign ready  = up && (state == CH_IDLE);
    assign strobe = (state == CH_REQ);
    assign oe     = (state != CH_IDLE);

endmodule

// File: rtl/bushost.sv
// Initiator end of the cartridge multiplexed address bus: 68k channel on J, AS
// channel on F. Optional macro ASADDR_CHECK_EN rejects AS addresses with a3 set.
module bushost
    import bus_pkg::*;
#(
    parameter int A68K_GAP = 2,
    parameter int AS_GAP   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_valid,
    output logic               m_ready,
    input  logic [A68K_AW-1:0] m_addr,
    input  logic               as_valid,
    output logic               as_ready,
    input  logic [AS_AW-1:0]   as_addr,
    output logic               as_err,
    output logic               a68kreq,
    output logic               asreq,
    input  logic [1:0]         js,
    output logic [15:0]        j,
    output logic               j_oe,
    input  logic [1:0]         fs,
    output logic [15:0]        f,
    output logic               f_oe
);

    logic [A68K_AW-1:0] m_hold;
    logic [AS_AW-1:0]   as_hold;
    logic               as_cvalid;
    logic [1:0]         sel_unused;

    bus_req_chan #(.AW(A68K_AW), .GAP(A68K_GAP)) u_jchan (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (m_valid),
        .ready  (m_ready),
        .addr   (m_addr),
        .hold   (m_hold),
        .strobe (a68kreq),
        .oe     (j_oe)
    );

    bus_req_chan #(.AW(AS_AW), .GAP(AS_GAP)) u_fchan (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (as_cvalid),
        .ready  (as_ready),
        .addr   (as_addr),
        .hold   (as_hold),
        .strobe (asreq),
        .oe     (f_oe)
    );

`ifdef ASADDR_CHECK_EN
    logic err_q;

    // A rejected address still completes the handshake but never reaches the channel.
    assign as_cvalid = as_valid && !as_addr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= as_valid && as_ready && as_addr[3];
    end

    assign as_err = err_q;
`else
    assign as_cvalid = as_valid;
    assign as_err    = 1'b0;
`endif

    // js=1x falls back to the low slice; the F bus carries one slice only, so fs is not decoded.
    assign j = (js == JS_HI) ? {13'b0, m_hold[18:16]} : m_hold[15:0];
    assign f = as_encode(as_hold);

    assign sel_unused = {fs == FS_AS, js == JS_LO};

endmodule

// File: tb/tb_bushost.sv
// Bench for bushost: directed vectors, a cycle-level behavioural model checked
// every cycle, and hand-computed literal checks.
module tb_bushost;
    import bus_pkg::*;

    localparam int MG = 2;
    localparam int AG = 3;

    logic        clk, rst_n;
    logic        m_valid, m_ready;
    logic [18:0] m_addr;
    logic        as_valid, as_ready;
    logic [16:0] as_addr;
    logic        as_err, a68kreq, asreq;
    logic [1:0]  js, fs;
    logic [15:0] j, f;
    logic        j_oe, f_oe;

    bushost #(.A68K_GAP(MG), .AS_GAP(AG)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .as_valid(as_valid), .as_ready(as_ready), .as_addr(as_addr), .as_err(as_err),
        .a68kreq(a68kreq), .asreq(asreq),
        .js(js), .j(j), .j_oe(j_oe),
        .fs(fs), .f(f), .f_oe(f_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: time-stamped events per channel, derived from accept cycles.
    int          cyc;
    logic        up, m_rdy, a_rdy;
    int          m_req, m_free, a_req, a_free, e_at;
    logic [18:0] mh;
    logic [16:0] ah;
    int          mq[$];

    function automatic logic [15:0] jexp(input logic [18:0] h, input logic [1:0] s);
        if (s == 2'b01) return 16'(h >> 16);
        return 16'(h & 19'h0FFFF);
    endfunction

    function automatic logic [15:0] fexp(input logic [16:0] h);
        int v;
        v = ((int'(h) >> 4) & 1) * 32768 + (int'(h) & 7) * 4096 + (int'(h) >> 5);
        return 16'(v);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cyc = 0; up = 0; m_rdy = 0; a_rdy = 0;
                mh = '0; ah = '0;
                m_req = -100; a_req = -100; e_at = -100;
                m_free = 0; a_free = 0;
            end else begin
                cyc++;
                if (m_valid && m_rdy) begin
                    mh = m_addr; m_req = cyc; m_free = cyc + MG;
                end
                if (as_valid && a_rdy) begin
`ifdef ASADDR_CHECK_EN
                    if (as_addr[3]) e_at = cyc;
                    else begin ah = as_addr; a_req = cyc; a_free = cyc + AG; end
`else
                    ah = as_addr; a_req = cyc; a_free = cyc + AG;
`endif
                end
                up    = 1;
                m_rdy = (cyc >= m_free);
                a_rdy = (cyc >= a_free);
            end
            #1;
            if (!rst_n) begin
                chk("rst_m_ready", m_ready, 0);
                chk("rst_as_ready", as_ready, 0);
                chk("rst_strobes", {a68kreq, asreq, as_err}, 0);
                chk("rst_oe", {j_oe, f_oe}, 0);
                chk("rst_j", j, 0);
                chk("rst_f", f, 0);
            end else begin
                chk("m_ready", m_ready, m_rdy);
                chk("as_ready", as_ready, a_rdy);
                chk("a68kreq", a68kreq, cyc == m_req);
                chk("asreq", asreq, cyc == a_req);
                chk("as_err", as_err, cyc == e_at);
                chk("j_oe", j_oe, (cyc >= m_req) && (cyc < m_req + MG));
                chk("f_oe", f_oe, (cyc >= a_req) && (cyc < a_req + AG));
                chk("j", j, jexp(mh, js));
                chk("f", f, fexp(ah));
                if (a68kreq) mq.push_back(cyc);
            end
        end
    end

    task automatic accept_m(input logic [18:0] a);
        int n;
        @(negedge clk);
        m_valid = 1'b1; m_addr = a;
        n = 0;
        while (!m_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("m_accept_timeout", 0, 1);
        @(posedge clk); #2;
    endtask

    task automatic accept_a(input logic [16:0] a);
        int n;
        @(negedge clk);
        as_valid = 1'b1; as_addr = a;
        n = 0;
        while (!as_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("as_accept_timeout", 0, 1);
        @(posedge clk); #2;
    endtask

    task automatic both_idle;
        int n;
        n = 0;
        while (!(m_ready && as_ready) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [18:0] b2b [3];

    initial begin
        rst_n = 0; m_valid = 0; as_valid = 0; m_addr = '0; as_addr = '0;
        js = 2'b00; fs = 2'b11;
        repeat (2) @(negedge clk);
        chk("hold_rst_ready", m_ready, 0);
        rst_n = 1;
        #1 chk("release_ready_early", {m_ready, as_ready}, 2'b00);
        @(posedge clk); #2;
        chk("release_ready", {m_ready, as_ready}, 2'b11);

        // 68k slice select
        accept_m(19'h5A5A5);
        chk("m_strobe", a68kreq, 1);
        chk("m_j_lo", j, 16'hA5A5);
        chk("m_j_oe", j_oe, 1);
        @(negedge clk); m_valid = 0; js = 2'b01;
        @(posedge clk); #2;
        chk("m_j_hi", j, 16'h0005);
        chk("m_ready_hold", m_ready, 0);
        @(negedge clk); js = 2'b10;
        #1 chk("m_j_js10", j, 16'hA5A5);
        js = 2'b00;
        repeat (3) @(negedge clk);

        // back-to-back 68k offers with valid held
        b2b[0] = 19'h00001; b2b[1] = 19'h7FFFF; b2b[2] = 19'h12345;
        mq.delete();
        for (int k = 0; k < 3; k++) accept_m(b2b[k]);
        @(negedge clk); m_valid = 0;
        repeat (5) @(negedge clk);
        chk("b2b_count", mq.size(), 3);
        if (mq.size() == 3) begin
            chk("b2b_gap0", mq[1] - mq[0], 3);
            chk("b2b_gap1", mq[2] - mq[1], 3);
        end

        // AS channel
        accept_a(17'h1_2345);
        chk("as_strobe", asreq, 1);
        chk("as_f", f, 16'h591A);
        chk("as_f_oe", f_oe, 1);
        @(negedge clk); as_valid = 0;
        @(posedge clk); #2;
        chk("as_hold1", {f_oe, as_ready, asreq}, 3'b100);
        @(posedge clk); #2;
        chk("as_hold2", {f_oe, as_ready, asreq}, 3'b100);
        chk("as_f_hold2", f, 16'h591A);
        @(posedge clk); #2;
        chk("as_idle", {f_oe, as_ready}, 2'b01);
        chk("as_f_kept", f, 16'h591A);

        // a3 set
        accept_a(17'h0_0008);
`ifdef ASADDR_CHECK_EN
        chk("a3_err", as_err, 1);
        chk("a3_no_strobe", asreq, 0);
`else
        chk("a3_strobe", asreq, 1);
        chk("a3_f", f, 16'h0000);
`endif
        @(negedge clk); as_valid = 0;

        // simultaneous offers
        both_idle();
        m_valid = 1; m_addr = 19'h3C0DE; as_valid = 1; as_addr = 17'h0_A5B2;
        @(posedge clk); #2;
        chk("sim_strobes", {a68kreq, asreq}, 2'b11);
        chk("sim_j", j, 16'hC0DE);
        chk("sim_f", f, 16'hA52D);
        @(negedge clk); m_valid = 0; as_valid = 0; js = 2'b01;
        @(posedge clk); #2;
        chk("sim_j_hi", j, 16'h0003);
        chk("sim_f_hold", f, 16'hA52D);
        @(negedge clk); js = 2'b00;

        // reset mid-HOLD
        both_idle();
        m_valid = 1; m_addr = 19'h01234; as_valid = 1; as_addr = 17'h0_00F0;
        @(posedge clk); @(posedge clk); #2;
        chk("pre_rst_oe", {j_oe, f_oe}, 2'b11);
        rst_n = 0;
        #1;
        chk("rst_async_strobes", {a68kreq, asreq}, 0);
        chk("rst_async_oe", {j_oe, f_oe}, 0);
        chk("rst_async_ready", {m_ready, as_ready}, 0);
        chk("rst_async_j", j, 0);
        @(negedge clk); m_valid = 0; as_valid = 0;
        @(negedge clk); rst_n = 1;
        #1 chk("rst_rel_early", {m_ready, as_ready}, 0);
        @(posedge clk); #2;
        chk("rst_rel_ready", {m_ready, as_ready}, 2'b11);
        chk("rst_rel_oe", {j_oe, f_oe}, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
